// File: rtl/fifo_share_ctrl.sv
// Round-robin two-producer write arbiter and wrap-bit pointer sequencer for one shared FIFO RAM.
// Grants are combinational, pop data is valid 1 cycle later, and full withholds both grants.
module fifo_share_ctrl #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             req1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic             rd_en,
  output logic             mem_we,
  output logic [SIZE-2:0]  mem_waddr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [SIZE-2:0]  mem_raddr,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [SIZE-1:0]  count,
  output logic             underflow
);

  logic [SIZE-1:0] w_ptr;
  logic [SIZE-1:0] r_ptr;
  logic            last_gnt;
  logic            pop;

  // Status depends only on registered pointers, never on same-cycle traffic.
  assign full  = (w_ptr[SIZE-1] != r_ptr[SIZE-1]) && (w_ptr[SIZE-2:0] == r_ptr[SIZE-2:0]);
  assign empty = (w_ptr == r_ptr);
  assign count = w_ptr - r_ptr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!full) begin
      if (req0 && req1) begin
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign mem_we    = gnt0 | gnt1;
  assign mem_wdata = gnt1 ? wdata1 : wdata0;
  assign mem_waddr = w_ptr[SIZE-2:0];
  assign mem_raddr = r_ptr[SIZE-2:0];
  assign pop       = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      last_gnt  <= 1'b1;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (mem_we) begin
        w_ptr    <= w_ptr + SIZE'(1);
        last_gnt <= gnt1;
      end
      if (pop) begin
        r_ptr <= r_ptr + SIZE'(1);
      end
      rd_valid <= pop;
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Directed plus randomized bench for fifo_share_ctrl against an occupancy-count reference model.
module tb_fifo_share_ctrl;
  localparam int SIZE  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 1 << (SIZE - 1);

  logic             clk;
  logic             rst_n;
  logic             req0, req1, rd_en;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, mem_we, rd_valid, full, empty, underflow;
  logic [SIZE-2:0]  mem_waddr, mem_raddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [SIZE-1:0]  count;

  fifo_share_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wdata0(wdata0), .req1(req1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rd_en(rd_en),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
    .rd_valid(rd_valid), .full(full), .empty(empty), .count(count), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: total pushes/pops ever accepted, plus who won the last contested-or-not grant.
  int wcnt, rcnt, lastg;
  bit exp_uf, exp_rv;

  task automatic model_reset();
    wcnt = 0; rcnt = 0; lastg = 1; exp_uf = 0; exp_rv = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r0, input logic [WIDTH-1:0] d0,
                      input bit r1, input logic [WIDTH-1:0] d1, input bit rd);
    int occ;
    bit eg0, eg1, push, popm;
    req0 = r0; wdata0 = d0; req1 = r1; wdata1 = d1; rd_en = rd;
    #1;
    occ = wcnt - rcnt;
    eg0 = 0; eg1 = 0;
    if (occ < DEPTH) begin
      if (r0 && r1) begin
        eg0 = (lastg == 1);
        eg1 = (lastg == 0);
      end else begin
        eg0 = r0;
        eg1 = r1;
      end
    end
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("mem_we", mem_we, eg0 | eg1);
    chk("mem_wdata", mem_wdata, eg1 ? d1 : d0);
    chk("mem_waddr", mem_waddr, wcnt % DEPTH);
    chk("mem_raddr", mem_raddr, rcnt % DEPTH);
    chk("full", full, occ == DEPTH);
    chk("empty", empty, occ == 0);
    chk("count", count, occ);
    chk("rd_valid", rd_valid, exp_rv);
    chk("underflow", underflow, exp_uf);
    @(posedge clk);
    push = eg0 | eg1;
    popm = rd && (occ != 0);
    if (rd && occ == 0) exp_uf = 1;
    if (push) begin
      wcnt++;
      lastg = eg1 ? 1 : 0;
    end
    if (popm) rcnt++;
    exp_rv = popm;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req0 = 0; req1 = 0; rd_en = 0; wdata0 = '0; wdata1 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset/idle state, then an asynchronous reset in the middle of a burst.
    step(0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h10 + 8'(i), 0, 8'h00, 1'(i == 2));
    req0 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    req0 = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 0, 8'h00, 0);

    // Contention to full: alternating grants, then backpressure.
    for (int n = 0; n < 10; n++) step(1, 8'hA0 + 8'(n), 1, 8'hB0 + 8'(n), 0);
    // Pop from full with req0 held.
    for (int n = 0; n < 8; n++) step(1, 8'hC0 + 8'(n), 0, 8'h00, 1);
    // Drain to empty.
    for (int n = 0; n < 10; n++) step(0, 8'h00, 0, 8'h00, 1);
    // req1 alone, interleaved with pops, wrapping the pointers.
    for (int n = 0; n < 20; n++) begin
      step(0, 8'h00, 1, 8'h50 + 8'(n), 0);
      step(0, 8'h00, 0, 8'h00, 1);
    end
    // Underflow from empty, then pop together with a push from empty.
    step(0, 8'h00, 0, 8'h00, 1);
    step(0, 8'h00, 0, 8'h00, 1);
    step(1, 8'h77, 0, 8'h00, 1);
    step(0, 8'h00, 0, 8'h00, 0);
    // Fill to 7, push+pop holds at 7, final push makes full.
    for (int n = 0; n < 6; n++) step(1, 8'h60 + 8'(n), 0, 8'h00, 0);
    step(1, 8'h6A, 0, 8'h00, 1);
    step(1, 8'h6B, 0, 8'h00, 0);
    step(0, 8'h00, 0, 8'h00, 0);

    // Randomized traffic with phases biased toward filling or draining.
    for (int n = 0; n < 400; n++) begin
      bit fillp;
      fillp = ((n / 40) % 2) == 0;
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
           fillp ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
